// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the PC, keeps at most one imem request in
// flight, and buffers fetched words in a small FIFO that feeds decode.
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [3:0]         func,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               halted
);
    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(2);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HALTED} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               take_halt;
    logic               take_redirect;
    logic               flush;
    logic               push;
    logic               pop;

    // Halt outranks redirect; either one empties the FIFO and suppresses push/pop.
    assign instr_valid   = (count != '0);
    assign take_halt     = instr_valid && halt;
    assign take_redirect = redirect && !take_halt && (state != HALTED);
    assign flush         = take_halt || take_redirect;
    assign push          = (state == WAIT) && imem_ack && !flush;
    assign pop           = instr_valid && instr_ready && !flush;

    assign imem_addr = pc;
    assign instr     = fifo_instr[rd_ptr];
    assign instr_pc  = fifo_pc[rd_ptr];
    assign opcode    = instr[INSTR_W-1 -: 4];
    assign func      = instr[3:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            imem_req <= 1'b0;
            halted   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            if (take_halt) begin
                state    <= HALTED;
                imem_req <= 1'b0;
                halted   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (take_redirect) pc <= redirect_pc;
                        // Pre-pop occupancy is used, so a full FIFO never gains an extra word.
                        if (count < FULL) begin
                            imem_req <= 1'b1;
                            state    <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (take_redirect) begin
                            pc       <= redirect_pc;
                            imem_req <= 1'b0;
                            state    <= imem_ack ? IDLE : DRAIN;
                        end else if (imem_ack) begin
                            pc       <= pc + STEP;
                            imem_req <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    DRAIN: begin
                        if (take_redirect) pc <= redirect_pc;
                        if (imem_ack) state <= IDLE;
                    end
                    HALTED: begin
                        imem_req <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory responder, directed corner cases,
// a redirect vector table and a randomized run against a pop-order model.
module tb_instr_fetch;
    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [3:0]  func;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [15:0] req_q[$];
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;
    logic [15:0] mem_addr = '0;

    typedef struct {
        logic [15:0] target;
        int          lat;
        logic [15:0] exp_pc0;
        logic [15:0] exp_pc1;
    } vec_t;

    vec_t vecs[5];

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .opcode      (opcode),
        .func        (func),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0100) return 16'h0123;
        return (a * 16'h9E37) ^ 16'h5A3C;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic rd, input logic [15:0] rpc,
                                  input logic hl, input logic rdy);
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        instr_ready = rdy;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic redirect_pulse(input logic [15:0] rpc, input logic rdy);
        apply_stimulus(1'b1, rpc, 1'b0, rdy);
        step();
        apply_stimulus(1'b0, rpc, 1'b0, rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        step();
        req_q.delete();
        rst_n = 1'b1;
    endtask

    // Evaluated at a negedge; a pop happens at the following posedge.
    task automatic wait_pop(output logic [15:0] pc, output logic [15:0] word, output bit ok);
        ok   = 1'b0;
        pc   = '0;
        word = '0;
        for (int i = 0; i < 100; i++) begin
            if (instr_valid && instr_ready && !redirect && !halt) begin
                pc   = instr_pc;
                word = instr;
                ok   = 1'b1;
                step();
                break;
            end
            step();
        end
    endtask

    task automatic expect_pop(input string name, input logic [15:0] exp_pc);
        logic [15:0] pc;
        logic [15:0] word;
        bit          ok;
        wait_pop(pc, word, ok);
        check_output({name, "_seen"}, 32'(ok), 32'd1);
        check_output({name, "_pc"}, 32'(pc), 32'(exp_pc));
        check_output({name, "_instr"}, 32'(word), 32'(mem_word(exp_pc)));
    endtask

    task automatic wait_reqs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (req_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Memory responder: answers every request it sees exactly once after mem_lat cycles.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mem_busy = 1'b0;
            imem_ack = 1'b0;
        end else begin
            imem_ack = 1'b0;
            if (mem_busy) begin
                if (imem_req) check_output("addr_stable", 32'(imem_addr), 32'(mem_addr));
                if (mem_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(mem_addr);
                    mem_busy   = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end else if (imem_req) begin
                mem_addr = imem_addr;
                req_q.push_back(imem_addr);
                if (mem_lat == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(mem_addr);
                end else begin
                    mem_busy = 1'b1;
                    mem_cnt  = mem_lat - 1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          ok;
        int          n;
        int          bad;
        logic [15:0] exp_pc;
        bit          prev_rd;
        logic        rd;
        logic        rdy;
        logic [15:0] rpc;

        vecs[0] = '{16'h0010, 0, 16'h0010, 16'h0012};
        vecs[1] = '{16'h1234, 1, 16'h1234, 16'h1236};
        vecs[2] = '{16'hFFFE, 2, 16'hFFFE, 16'h0000};
        vecs[3] = '{16'h8000, 3, 16'h8000, 16'h8002};
        vecs[4] = '{16'h7FFE, 1, 16'h7FFE, 16'h8000};

        imem_ack   = 1'b0;
        imem_rdata = '0;

        // In-order fetch with ack one cycle after req; halt ignored while nothing is valid.
        mem_lat = 1;
        do_reset();
        check_output("rst_req", 32'(imem_req), 32'd0);
        check_output("rst_valid", 32'(instr_valid), 32'd0);
        check_output("rst_halted", 32'(halted), 32'd0);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        step();
        check_output("first_req", 32'(imem_req), 32'd1);
        check_output("first_addr", 32'(imem_addr), 32'h0000);
        check_output("halt_no_valid", 32'(halted), 32'd0);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        expect_pop("t1_w0", 16'h0000);
        expect_pop("t1_w1", 16'h0002);
        expect_pop("t1_w2", 16'h0004);
        wait_reqs(3, ok);
        check_output("t1_reqs_seen", 32'(ok), 32'd1);
        check_output("t1_req0", 32'(req_q[0]), 32'h0000);
        check_output("t1_req1", 32'(req_q[1]), 32'h0002);
        check_output("t1_req2", 32'(req_q[2]), 32'h0004);

        // Back-pressure: FIFO fills, requests stop, then resume after pops.
        do_reset();
        for (int i = 0; i < 20; i++) step();
        check_output("t2_req_count", 32'(req_q.size()), 32'd2);
        check_output("t2_req_idle", 32'(imem_req), 32'd0);
        check_output("t2_valid", 32'(instr_valid), 32'd1);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        expect_pop("t2_w0", 16'h0000);
        expect_pop("t2_w1", 16'h0002);
        wait_reqs(3, ok);
        check_output("t2_resume_seen", 32'(ok), 32'd1);
        check_output("t2_resume_addr", 32'(req_q[2]), 32'h0004);

        // Redirect while waiting on addr 6: late ack must be dropped.
        mem_lat = 3;
        do_reset();
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (imem_req && imem_addr == 16'h0006) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check_output("t3_wait6_seen", 32'(ok), 32'd1);
        n = req_q.size();
        redirect_pulse(16'h0040, 1'b1);
        check_output("t3_valid_after_redirect", 32'(instr_valid), 32'd0);
        wait_reqs(n + 1, ok);
        check_output("t3_next_req_seen", 32'(ok), 32'd1);
        check_output("t3_next_addr", 32'(req_q[n]), 32'h0040);
        expect_pop("t3_first", 16'h0040);

        // Redirect coincident with ack: that word is never delivered.
        mem_lat = 0;
        do_reset();
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (imem_ack && req_q.size() >= 3) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check_output("t4_ack_seen", 32'(ok), 32'd1);
        n = req_q.size();
        redirect_pulse(16'h0200, 1'b1);
        check_output("t4_valid_after_redirect", 32'(instr_valid), 32'd0);
        wait_reqs(n + 1, ok);
        check_output("t4_next_req_seen", 32'(ok), 32'd1);
        check_output("t4_next_addr", 32'(req_q[n]), 32'h0200);
        expect_pop("t4_first", 16'h0200);

        // Halt on an opcode-0 head word, with redirect in the same cycle.
        mem_lat = 1;
        do_reset();
        redirect_pulse(16'h0100, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check_output("t5_valid_seen", 32'(ok), 32'd1);
        check_output("t5_head_pc", 32'(instr_pc), 32'h0100);
        check_output("t5_head_opcode", 32'(opcode), 32'h0);
        check_output("t5_head_func", 32'(func), 32'h3);
        apply_stimulus(1'b1, 16'h0300, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b0, 16'h0300, 1'b0, 1'b1);
        check_output("t5_halted", 32'(halted), 32'd1);
        check_output("t5_req_off", 32'(imem_req), 32'd0);
        check_output("t5_valid_off", 32'(instr_valid), 32'd0);
        n   = req_q.size();
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(($urandom_range(0, 3) == 0), 16'h0300, 1'b0, 1'($urandom_range(0, 1)));
            step();
            if (!(halted && !imem_req && !instr_valid)) bad++;
        end
        check_output("t5_halt_sticky", 32'(bad), 32'd0);
        check_output("t5_no_new_reqs", 32'(req_q.size()), 32'(n));

        // Asynchronous reset mid-WAIT with a word buffered, then PC wrap.
        mem_lat = 3;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (instr_valid && imem_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check_output("t6_wait_seen", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t6_async_req", 32'(imem_req), 32'd0);
        check_output("t6_async_valid", 32'(instr_valid), 32'd0);
        check_output("t6_async_halted", 32'(halted), 32'd0);
        do_reset();
        step();
        check_output("t6_req_after_rst", 32'(imem_req), 32'd1);
        check_output("t6_addr_after_rst", 32'(imem_addr), 32'h0000);
        redirect_pulse(16'hFFFE, 1'b1);
        expect_pop("t6_wrap0", 16'hFFFE);
        expect_pop("t6_wrap1", 16'h0000);

        // Redirect vector table applied back to back on a streaming fetcher.
        for (int v = 0; v < 5; v++) begin
            mem_lat = vecs[v].lat;
            redirect_pulse(vecs[v].target, 1'b1);
            check_output($sformatf("vec%0d_valid_off", v), 32'(instr_valid), 32'd0);
            expect_pop($sformatf("vec%0d_w0", v), vecs[v].exp_pc0);
            expect_pop($sformatf("vec%0d_w1", v), vecs[v].exp_pc1);
        end

        // Random ready/redirect/latency against a sequential-PC pop model.
        do_reset();
        exp_pc  = 16'h0000;
        prev_rd = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (prev_rd) check_output("rnd_valid_after_redirect", 32'(instr_valid), 32'd0);
            rd      = ($urandom_range(0, 15) == 0);
            rpc     = 16'($urandom_range(0, 65535)) & 16'hFFFE;
            rdy     = ($urandom_range(0, 3) != 0);
            mem_lat = $urandom_range(0, 3);
            apply_stimulus(rd, rpc, 1'b0, rdy);
            if (instr_valid && rdy && !rd) begin
                check_output("rnd_pc", 32'(instr_pc), 32'(exp_pc));
                check_output("rnd_instr", 32'(instr), 32'(mem_word(exp_pc)));
                check_output("rnd_opcode", 32'(opcode), 32'(mem_word(exp_pc) >> 12));
                check_output("rnd_func", 32'(func), 32'(mem_word(exp_pc) & 16'h000F));
                exp_pc = exp_pc + 16'd2;
            end
            if (rd) exp_pc = rpc;
            prev_rd = rd;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
